// File: rtl/spi_pkg.sv
// Shared SPI definitions: command opcodes and responder state encoding,
// used by both the responder and the initiator-side code.
package spi_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        WRITE,
        IGNORE
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, plus edge detection
// of the synchronised value against its previous value.
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1   <= RESET_VAL;
            s2   <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 RAM responder: opcode 0x03 streams reads, 0x02 streams writes,
// both from an address pointer that wraps at MEM_BYTES.
module spi_ram_responder
    import spi_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_BITS = 24
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         spi_select,
    input  logic                         spi_clk,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    input  logic [$clog2(MEM_BYTES)-1:0] dbg_addr,
    output logic [7:0]                   dbg_data,
    output logic                         busy
);

    localparam int PTR_W = $clog2(MEM_BYTES);
    localparam int CNT_W = $clog2(ADDR_BITS);
    localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_BITS - 1);

    logic sel_s, sel_fall, sel_rise;
    logic sck_rise, sck_fall, sck_s;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync #(.RESET_VAL(1'b1)) u_sync_sel (
        .clk(clk), .rstn(rstn), .d(spi_select), .sync(sel_s), .rise(sel_rise), .fall(sel_fall));
    spi_sync #(.RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rstn(rstn), .d(spi_clk), .sync(sck_s), .rise(sck_rise), .fall(sck_fall));
    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rstn(rstn), .d(spi_mosi), .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    logic unused_edges;
    assign unused_edges = &{1'b0, sel_rise, sck_s, mosi_rise, mosi_fall};

    logic [7:0]       mem [MEM_BYTES];
    spi_state_e       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] ptr;
    logic [6:0]       cmd_sr;
    logic [PTR_W-2:0] addr_sr;
    logic [6:0]       wr_sr;
    logic [7:0]       out_sr;
    logic [7:0]       wr_byte;
    logic             wr_pend;
    logic             is_read;

    // Shift-in values including the bit arriving on this edge.
    logic [7:0]       new_cmd;
    logic [PTR_W-1:0] new_ptr;
    logic [7:0]       new_wr;
    logic [PTR_W-1:0] ptr_inc;

    assign new_cmd = {cmd_sr, mosi_s};
    assign new_ptr = {addr_sr, mosi_s};
    assign new_wr  = {wr_sr, mosi_s};
    assign ptr_inc = ptr + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (sel_s) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (sel_fall) state_n = CMD;
                CMD: if (sck_rise && cnt == CNT_BYTE)
                    state_n = (new_cmd == CMD_READ || new_cmd == CMD_WRITE) ? ADDR : IGNORE;
                ADDR: if (sck_rise && cnt == CNT_ADDR) state_n = is_read ? READ : WRITE;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            ptr      <= '0;
            cmd_sr   <= '0;
            addr_sr  <= '0;
            wr_sr    <= '0;
            out_sr   <= '0;
            wr_byte  <= '0;
            wr_pend  <= 1'b0;
            is_read  <= 1'b0;
            spi_miso <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (wr_pend) ptr <= ptr_inc;
            // A completed byte commits even if select rises on its last edge.
            if (state == WRITE && sck_rise) begin
                wr_sr <= new_wr[6:0];
                if (cnt == CNT_BYTE) begin
                    wr_pend <= 1'b1;
                    wr_byte <= new_wr;
                end
            end
            if (sel_s) begin
                cnt      <= '0;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    CMD: if (sck_rise) begin
                        cmd_sr <= new_cmd[6:0];
                        if (cnt == CNT_BYTE) begin
                            cnt     <= '0;
                            is_read <= (new_cmd == CMD_READ);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ADDR: if (sck_rise) begin
                        addr_sr <= new_ptr[PTR_W-2:0];
                        if (cnt == CNT_ADDR) begin
                            cnt    <= '0;
                            ptr    <= new_ptr;
                            out_sr <= mem[new_ptr];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    READ: if (sck_fall) begin
                        spi_miso <= out_sr[7];
                        if (cnt == CNT_BYTE) begin
                            cnt    <= '0;
                            ptr    <= ptr_inc;
                            out_sr <= mem[ptr_inc];
                        end else begin
                            cnt    <= cnt + 1'b1;
                            out_sr <= {out_sr[6:0], 1'b0};
                        end
                    end
                    WRITE: if (sck_rise) cnt <= (cnt == CNT_BYTE) ? '0 : cnt + 1'b1;
                    default: spi_miso <= 1'b0;
                endcase
            end
        end
    end

    // Memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_pend) mem[ptr] <= wr_byte;
    end

    assign dbg_data = mem[dbg_addr];
    assign busy     = ~sel_s;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: bit-banged SPI master, shadow memory model,
// expected-byte queue for read data, vector table plus corner sequences.
module tb_spi_ram_responder;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rstn;
    logic       spi_select;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       busy;

    spi_ram_responder #(.MEM_BYTES(256), .ADDR_BITS(24)) dut (
        .clk(clk), .rstn(rstn), .spi_select(spi_select), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .busy(busy));

    // clock / reset
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] shadow[256];

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  exp_ptr;
    } vec_t;
    vec_t vecs[6];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(HALF);
            rx = {rx[6:0], spi_miso};
            spi_clk = 1'b1;
            wait_clk(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic sel_begin();
        spi_select = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic sel_end();
        wait_clk(HALF);
        spi_select = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr);
        logic [7:0] rx;
        sel_begin();
        xfer(op, 8, rx);
        xfer(addr[23:16], 8, rx);
        xfer(addr[15:8], 8, rx);
        xfer(addr[7:0], 8, rx);
    endtask

    task automatic write2(input logic [23:0] addr, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] rx;
        send_hdr(8'h02, addr);
        xfer(d0, 8, rx);
        xfer(d1, 8, rx);
        sel_end();
    endtask

    task automatic read_check(input string name, input logic [23:0] addr, input int n);
        logic [7:0] rx;
        logic [7:0] base;
        base = addr[7:0];
        send_hdr(8'h03, addr);
        check("busy_sel", {7'd0, busy}, 8'd1);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(shadow[8'(base + k)]);
            xfer(8'h00, 8, rx);
            check(name, rx, exp_q.pop_front());
        end
        sel_end();
    endtask

    task automatic check_all_mem(input string name);
        for (int i = 0; i < 256; i++) begin
            dbg_addr = 8'(i);
            #1;
            check(name, dbg_data, shadow[i]);
        end
    endtask

    initial begin
        logic [7:0] rx;

        vecs[0] = '{24'h000010, 8'hA5, 8'h5A, 8'h10};
        vecs[1] = '{24'h0000FF, 8'h11, 8'h22, 8'hFF};
        vecs[2] = '{24'hABCD42, 8'hC3, 8'h3C, 8'h42};
        vecs[3] = '{24'h000080, 8'h00, 8'hFF, 8'h80};
        for (int v = 4; v < 6; v++) begin
            vecs[v].exp_ptr = 8'($urandom_range(8'h50, 8'h7E));
            vecs[v].addr    = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), vecs[v].exp_ptr};
            vecs[v].d0      = 8'($urandom_range(0, 255));
            vecs[v].d1      = 8'($urandom_range(0, 255));
        end

        rstn = 1'b0; spi_select = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; dbg_addr = '0;
        wait_clk(4);
        check("rst_miso", {7'd0, spi_miso}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        rstn = 1'b1;
        wait_clk(4);
        check("idle_busy", {7'd0, busy}, 8'd0);

        // Fill memory with a known pattern in one streamed write.
        send_hdr(8'h02, 24'h000000);
        for (int i = 0; i < 256; i++) begin
            shadow[i] = 8'(i * 7 + 3);
            xfer(shadow[i], 8, rx);
        end
        sel_end();
        check_all_mem("init_mem");

        for (int v = 0; v < 6; v++) begin
            write2(vecs[v].addr, vecs[v].d0, vecs[v].d1);
            shadow[vecs[v].exp_ptr] = vecs[v].d0;
            shadow[8'(vecs[v].exp_ptr + 1)] = vecs[v].d1;
            dbg_addr = vecs[v].exp_ptr;
            #1;
            check("vec_dbg0", dbg_data, vecs[v].d0);
            dbg_addr = 8'(vecs[v].exp_ptr + 1);
            #1;
            check("vec_dbg1", dbg_data, vecs[v].d1);
            read_check("vec_read", vecs[v].addr, 2);
        end

        // Unknown opcode: miso silent, mosi traffic must not write.
        sel_begin();
        xfer(8'h9F, 8, rx);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back(8'h00);
            xfer(8'h02 + 8'(b), 8, rx);
            check("ignore_miso", rx, exp_q.pop_front());
        end
        sel_end();
        check_all_mem("ignore_mem");

        // Partial byte discarded, next transaction decodes normally.
        send_hdr(8'h02, 24'h000020);
        xfer(8'hFF, 5, rx);
        sel_end();
        dbg_addr = 8'h20;
        #1;
        check("partial_mem", dbg_data, shadow[8'h20]);
        read_check("after_partial", 24'h000020, 2);

        // Select rises on the same clock as the 8th data edge.
        send_hdr(8'h02, 24'h000030);
        xfer(8'h96, 7, rx);
        spi_mosi = 1'b0;
        wait_clk(HALF);
        spi_clk = 1'b1;
        spi_select = 1'b1;
        wait_clk(HALF);
        spi_clk = 1'b0;
        wait_clk(8);
        shadow[8'h30] = 8'h96;
        dbg_addr = 8'h30;
        #1;
        check("coincident_wr", dbg_data, 8'h96);

        // Reset during read data phase.
        send_hdr(8'h03, 24'h000010);
        xfer(8'h00, 4, rx);
        wait_clk(2);
        rstn = 1'b0;
        #1;
        check("midrst_miso", {7'd0, spi_miso}, 8'd0);
        check("midrst_busy", {7'd0, busy}, 8'd0);
        spi_select = 1'b1;
        spi_clk = 1'b0;
        wait_clk(3);
        rstn = 1'b1;
        wait_clk(4);
        dbg_addr = 8'h10;
        #1;
        check("post_rst_dbg", dbg_data, 8'hA5);
        read_check("post_rst_read", 24'h000010, 1);
        check_all_mem("final_mem");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_responder.md
SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 256, number of byte locations (power of two, 16..4096).
REQ-002 SHALL have parameter ADDR_BITS, default 24, number of address bits in the serial command.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port spi_select  input  1  chip select, active-low.
REQ-006 SHALL have port spi_clk  input  1  serial clock, mode 0, at most clk/4.
REQ-007 SHALL have port spi_mosi  input  1  serial data in, MSB first.
REQ-008 SHALL have port spi_miso  output  1  serial data out, MSB first, registered.
REQ-009 SHALL have port dbg_addr  input  log2(MEM_BYTES)  backdoor read address.
REQ-010 SHALL have port dbg_data  output  8  mem[dbg_addr], combinational.
REQ-011 SHALL have port busy  output  1  high while select is low after synchronisation.

Function
REQ-012 SHALL pass spi_select, spi_clk and spi_mosi through 2-flop synchronisers; edges detected on the synchronised clk_s vs. its previous value.
REQ-013 SHALL sample mosi_s on each detected SCK rising edge; SHALL update spi_miso on each detected SCK falling edge only.
REQ-014 SHALL use states IDLE, CMD, ADDR, READ, WRITE, IGNORE; select_s high forces IDLE in the next cycle from any state, clears bit counter, drives spi_miso 0.
REQ-015 IDLE -> CMD when select_s falls; CMD collects 8 bits.
REQ-016 After 8th command bit: 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other value -> IGNORE.
REQ-017 ADDR collects ADDR_BITS bits; the internal pointer is those bits modulo MEM_BYTES (upper bits discarded).
REQ-018 Read: on the 32nd rising edge (last address bit), load mem[pointer] into the output shift register; the first falling edge after it drives bit 7; each following falling edge drives the next bit.
REQ-019 Read: after the 8th data bit is driven, the next byte mem[pointer+1] is loaded so bit 7 appears on the following falling edge with no gap; reads stream indefinitely.
REQ-020 Write: each 8 sampled data bits form a byte written to mem[pointer] in the cycle after the 8th rising edge; pointer then increments.
REQ-021 Pointer SHALL wrap from MEM_BYTES-1 to 0 for both reads and writes.
REQ-022 Select rising mid-byte SHALL discard the partial byte; no write occurs, memory unchanged.
REQ-023 IGNORE SHALL hold spi_miso at 0 and ignore mosi until select rises.
REQ-024 spi_miso SHALL be 0 in IDLE, CMD, ADDR, WRITE, IGNORE.
REQ-025 A select_s rise coincident with the 8th write edge SHALL still commit that completed byte.

Reset
REQ-026 rstn low SHALL asynchronously set state IDLE, spi_miso 0, busy 0, counters/pointer/shift registers 0, synchronisers to select=1, clk=0, mosi=0.
REQ-027 Memory contents SHALL NOT be cleared by reset; reset mid-transaction aborts it with no further write.

Structure
REQ-028 Command opcodes (0x02, 0x03) and state encoding SHALL be in shared package spi_pkg, reused by the initiator-side code.
REQ-029 One sub-module spi_sync (2-flop synchroniser plus edge detect) SHALL be instantiated per input; memory is an inferred array inside spi_ram_responder.

Verification
REQ-030 Write 02 000010 A5 5A, select high; read 03 000010, 16 clocks -> miso returns A5 then 5A; dbg_addr 0x10 -> dbg_data A5.
REQ-031 Write 02 0000FF 11 22 -> mem[0xFF]=11, mem[0x00]=22 (wrap); read 03 0000FF, 16 clocks -> 11, 22.
REQ-032 Command 0x9F then 32 clocks -> miso stays 0; memory unchanged at all addresses.
REQ-033 Write 02 000020 then 5 data bits, select high -> mem[0x20] unchanged; next transaction decodes normally.
REQ-034 Address 0xABCD42 with MEM_BYTES=256 -> access hits mem[0x42].
REQ-035 rstn low during read data phase -> spi_miso 0, busy 0 within the assert; after release, read 03 000010 still returns A5.
